// File: rtl/uart_tx_frame_pkg.sv
// Shared constants for the UART frame transmitter: board-clock baud divisors,
// parity codes and FSM state encodings (reused by the future receiver).
package uart_tx_frame_pkg;

  localparam int unsigned CLK_HZ  = 50_000_000;
  localparam int unsigned B9600   = CLK_HZ / 9600;
  localparam int unsigned B19200  = CLK_HZ / 19200;
  localparam int unsigned B57600  = CLK_HZ / 57600;
  localparam int unsigned B115200 = CLK_HZ / 115200;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  localparam int unsigned TIMER_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Producer-side handshake and serial outputs of uart_tx_frame.
// The producer uses the master modport, the transmitter the slave modport.
interface uart_tx_frame_if #(
  parameter int unsigned DATA_BITS = 8
) ();

  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;
  logic                 tx;
  logic                 done;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready,
    input  tx,
    input  done
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready,
    output tx,
    output done
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Loadable down-counter producing a one-cycle bit_end pulse every reload_i+1
// cycles while enabled; restart_i reloads it without emitting a pulse.
module uart_bit_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en_i,
  input  logic             restart_i,
  input  logic [WIDTH-1:0] reload_i,
  output logic             bit_end_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (restart_i) begin
      count_d = reload_i;
    end else if (en_i) begin
      if (count_q == '0) begin
        count_d = reload_i;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bit_end_o = en_i & ~restart_i & (count_q == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start + DATA_BITS (LSB first) + optional parity + STOP_BITS.
// Parity bit and PARITY state exist only when UART_TX_PARITY_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | line high, tx_ready high, waiting for a word
// ST_START  | driving the start bit (0)
// ST_DATA   | shifting out data bits, LSB first
// ST_PARITY | driving the accumulated parity bit
// ST_STOP   | driving STOP_BITS stop bits (1)
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int unsigned DIVISOR   = B9600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned PARITY    = PAR_NONE
) (
  input  logic           clk,
  input  logic           rstn,
  uart_tx_frame_if.slave bus
);

  if (DIVISOR < 2 || DIVISOR > 65535) begin : g_bad_divisor
    $error("uart_tx_frame: DIVISOR must be in 2..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (PARITY > PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end

  localparam logic [TIMER_W-1:0] RELOAD    = TIMER_W'(DIVISOR - 1);
  localparam logic [3:0]         LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]         LAST_STOP = 4'(STOP_BITS - 1);
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ACTIVE = (PARITY != PAR_NONE);
  localparam bit PAR_SEED   = (PARITY == PAR_ODD);
`endif

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  logic accept;
  logic bit_end;

  assign bus.tx_ready = (state_q == ST_IDLE);
  assign accept       = bus.tx_valid & bus.tx_ready;
  assign bus.tx       = tx_q;
  assign bus.done     = done_q;

  uart_bit_timer #(
    .WIDTH (TIMER_W)
  ) u_bit_timer (
    .clk       (clk),
    .rstn      (rstn),
    .en_i      (state_q != ST_IDLE),
    .restart_i (accept),
    .reload_i  (RELOAD),
    .bit_end_o (bit_end)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_START;
          shift_d = bus.tx_data;
          idx_d   = '0;
`ifdef UART_TX_PARITY_EN
          par_d   = PAR_SEED;
`endif
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
`ifdef UART_TX_PARITY_EN
          par_d   = par_q ^ shift_q[0];
`endif
          if (idx_q == LAST_DATA) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PAR_ACTIVE ? ST_PARITY : ST_STOP;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (idx_q == LAST_STOP) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // tx is registered, so it is derived from where the FSM is heading next
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations checked every cycle against a
// frame-level model, plus directed scenarios with hand-computed expectations.
module tb_uart_tx_frame;

  localparam int N = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PON = 1;
`else
  localparam int PON = 0;
`endif
  localparam int DIV [N] = '{4, 3, 4, 4};
  localparam int NB  [N] = '{8, 5, 8, 8};
  localparam int NS  [N] = '{1, 2, 1, 1};
  localparam int PM  [N] = '{0, 0, 2 * PON, PON};

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       drv_valid [N];
  logic [8:0] drv_data  [N];
  logic       obs_tx    [N];
  logic       obs_ready [N];
  logic       obs_done  [N];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  uart_tx_frame_if #(.DATA_BITS(8)) if0 ();
  uart_tx_frame_if #(.DATA_BITS(5)) if1 ();
  uart_tx_frame_if #(.DATA_BITS(8)) if2 ();
  uart_tx_frame_if #(.DATA_BITS(8)) if3 ();

  assign if0.tx_valid = drv_valid[0];
  assign if0.tx_data  = drv_data[0][7:0];
  assign if1.tx_valid = drv_valid[1];
  assign if1.tx_data  = drv_data[1][4:0];
  assign if2.tx_valid = drv_valid[2];
  assign if2.tx_data  = drv_data[2][7:0];
  assign if3.tx_valid = drv_valid[3];
  assign if3.tx_data  = drv_data[3][7:0];

  assign obs_tx[0] = if0.tx;  assign obs_ready[0] = if0.tx_ready;  assign obs_done[0] = if0.done;
  assign obs_tx[1] = if1.tx;  assign obs_ready[1] = if1.tx_ready;  assign obs_done[1] = if1.done;
  assign obs_tx[2] = if2.tx;  assign obs_ready[2] = if2.tx_ready;  assign obs_done[2] = if2.done;
  assign obs_tx[3] = if3.tx;  assign obs_ready[3] = if3.tx_ready;  assign obs_done[3] = if3.done;

  uart_tx_frame #(.DIVISOR(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY(0))
    u0 (.clk(clk), .rstn(rstn), .bus(if0));
  uart_tx_frame #(.DIVISOR(3), .DATA_BITS(5), .STOP_BITS(2), .PARITY(0))
    u1 (.clk(clk), .rstn(rstn), .bus(if1));
  uart_tx_frame #(.DIVISOR(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY(2))
    u2 (.clk(clk), .rstn(rstn), .bus(if2));
  uart_tx_frame #(.DIVISOR(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY(1))
    u3 (.clk(clk), .rstn(rstn), .bus(if3));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int nbits(input int i);
    return 1 + NB[i] + ((PM[i] != 0) ? 1 : 0) + NS[i];
  endfunction

  // Line levels of a whole frame, index 0 = start bit; unused positions stay 1.
  function automatic logic [15:0] frame_bits(input int i, input logic [8:0] d);
    logic [15:0] b;
    int k;
    int ones;
    b = '1;
    b[0] = 1'b0;
    k = 1;
    ones = 0;
    for (int j = 0; j < NB[i]; j++) begin
      b[k] = d[j];
      ones += d[j] ? 1 : 0;
      k++;
    end
    if (PM[i] == 1) b[k] = (ones % 2 == 0);
    if (PM[i] == 2) b[k] = (ones % 2 == 1);
    return b;
  endfunction

  logic        m_idle [N];
  logic        m_done [N];
  int          m_c    [N];
  logic [15:0] m_bits [N];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) begin
        m_idle[i] <= 1'b1;
        m_done[i] <= 1'b0;
        m_c[i]    <= 0;
        m_bits[i] <= '1;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_idle[i]) begin
          m_done[i] <= 1'b0;
          if (drv_valid[i]) begin
            m_idle[i] <= 1'b0;
            m_c[i]    <= 0;
            m_bits[i] <= frame_bits(i, drv_data[i]);
          end
        end else begin
          m_c[i] <= m_c[i] + 1;
          if (m_c[i] + 1 == nbits(i) * DIV[i]) begin
            m_idle[i] <= 1'b1;
            m_done[i] <= 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      check($sformatf("u%0d tx", i), 32'(obs_tx[i]),
            32'(m_idle[i] ? 1'b1 : m_bits[i][m_c[i] / DIV[i]]));
      check($sformatf("u%0d tx_ready", i), 32'(obs_ready[i]), 32'(m_idle[i]));
      check($sformatf("u%0d done", i), 32'(obs_done[i]), 32'(m_done[i]));
    end
  end

  logic [15:0] mid;
  int          len;

  // Sends one word, samples each bit mid-period and measures accept-to-done cycles.
  task automatic send_capture(input int i, input logic [8:0] d,
                              output logic [15:0] bits, output int cycles);
    bits = '1;
    cycles = -1;
    @(negedge clk);
    drv_valid[i] = 1'b1;
    drv_data[i]  = d;
    @(negedge clk);
    drv_valid[i] = 1'b0;
    check("accepted", 32'(obs_ready[i]), 32'd0);
    for (int c = 0; c < 2000; c++) begin
      if (obs_done[i]) begin
        cycles = c;
        break;
      end
      if (c % DIV[i] == DIV[i] / 2) bits[c / DIV[i]] = obs_tx[i];
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      drv_valid[i] = 1'b0;
      drv_data[i]  = '0;
    end

    repeat (3) @(negedge clk);
    check("reset tx", 32'(obs_tx[0]), 32'd1);
    check("reset tx_ready", 32'(obs_ready[0]), 32'd1);
    check("reset done", 32'(obs_done[0]), 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1, DIVISOR=4, 0xA5
    send_capture(0, 9'h0A5, mid, len);
    check("t1 bits", 32'(mid[9:0]), 32'h34A);
    check("t1 len", 32'(len), 32'd40);

    // back-to-back with tx_valid held high
    @(negedge clk);
    drv_valid[0] = 1'b1;
    drv_data[0]  = 9'h000;
    @(negedge clk);
    check("t2 accept1", 32'(obs_ready[0]), 32'd0);
    drv_data[0] = 9'h0FF;
    len = -1;
    for (int c = 0; c < 200; c++) begin
      if (obs_done[0]) begin
        len = c;
        break;
      end
      @(negedge clk);
    end
    check("t2 len1", 32'(len), 32'd40);
    check("t2 ready at done", 32'(obs_ready[0]), 32'd1);
    @(negedge clk);
    drv_valid[0] = 1'b0;
    check("t2 ready one cycle", 32'(obs_ready[0]), 32'd0);
    check("t2 start no gap", 32'(obs_tx[0]), 32'd0);
    len = -1;
    for (int c = 0; c < 200; c++) begin
      if (obs_done[0]) begin
        len = c;
        break;
      end
      @(negedge clk);
    end
    check("t2 len2", 32'(len), 32'd40);

    // parity instances: even and odd parity over 0x07
    send_capture(2, 9'h007, mid, len);
    check("t3 even head", 32'(mid[8:0]), 32'h00E);
    check("t3 even bit9", 32'(mid[9]), 32'd1);
    check("t3 even len", 32'(len), (PON != 0) ? 32'd44 : 32'd40);
    send_capture(3, 9'h007, mid, len);
    check("t3 odd head", 32'(mid[8:0]), 32'h00E);
    check("t3 odd bit9", 32'(mid[9]), (PON != 0) ? 32'd0 : 32'd1);
    check("t3 odd len", 32'(len), (PON != 0) ? 32'd44 : 32'd40);

    // 5 data bits, 2 stop bits, DIVISOR=3
    send_capture(1, 9'h01F, mid, len);
    check("t4 bits", 32'(mid[7:0]), 32'hFE);
    check("t4 len", 32'(len), 32'd24);

    // reset during data bit 3
    @(negedge clk);
    drv_valid[0] = 1'b1;
    drv_data[0]  = 9'h000;
    @(negedge clk);
    drv_valid[0] = 1'b0;
    repeat (17) @(negedge clk);
    check("t5 in data", 32'(obs_tx[0]), 32'd0);
    #2;
    rstn = 1'b0;
    #1;
    check("t5 abort tx", 32'(obs_tx[0]), 32'd1);
    check("t5 abort ready", 32'(obs_ready[0]), 32'd1);
    check("t5 abort done", 32'(obs_done[0]), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    send_capture(0, 9'h03C, mid, len);
    check("t5 bits", 32'(mid[9:0]), 32'h278);
    check("t5 len", 32'(len), 32'd40);

    // tx_valid pulse while busy must be ignored
    @(negedge clk);
    drv_valid[0] = 1'b1;
    drv_data[0]  = 9'h081;
    @(negedge clk);
    drv_valid[0] = 1'b0;
    len = -1;
    for (int c = 0; c < 200; c++) begin
      if (obs_done[0]) begin
        len = c;
        break;
      end
      drv_valid[0] = (c == 5);
      if (c == 5) drv_data[0] = 9'h055;
      @(negedge clk);
    end
    drv_valid[0] = 1'b0;
    check("t6 len", 32'(len), 32'd40);
    repeat (2) @(negedge clk);
    check("t6 stays idle tx", 32'(obs_tx[0]), 32'd1);
    check("t6 stays idle ready", 32'(obs_ready[0]), 32'd1);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
